// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the fetch entry record handed from fetch to decode.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC; wraps naturally at 2^PC_W.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, control from branch/decode, and the IF/ID handshake.
interface fetch_prefetch_unit_if
    import cpu_pkg::*;
();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;
    logic [PC_W-1:0]    id_pc1;
    logic               halted;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc1, halted,
        input  imem_rdata, redirect, redirect_pc, halt, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc1, halted,
        output imem_rdata, redirect, redirect_pc, halt, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular-buffer FIFO of fetch entries with flush; the head is read from
// registered storage so a push becomes visible one cycle later.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= bump(wr_ptr);
            if (do_pop)
                rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset)
            mem[wr_ptr] <= push_data;
    end

    assign head  = empty ? '0 : mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues at most one fetch per cycle under a queue-credit limit,
// queues responses for decode, and services branch redirects and a sticky halt.
module fetch_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                   clk,
    input logic                   reset,
    fetch_prefetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  tag_q;
    logic             inflight_q;
    logic             halted_q;
    logic             deq;
    logic             enq;
    logic             issue;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     head;
    fetch_entry_t     resp;

    // A slot is reserved for the in-flight word, so a queued response always has room.
    assign deq       = ~fifo_empty & bus.id_ready;
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(deq);
    assign issue     = ~reset & ~halted_q & ~bus.redirect & (int'(occupancy) < DEPTH);
    assign enq       = inflight_q & ~bus.redirect;
    assign resp      = '{pc: tag_q, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (enq),
        .push_data (resp),
        .pop       (deq),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Redirect outranks issue and the halt latch; a halted unit still tracks redirect_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (bus.redirect) begin
                pc_q <= bus.redirect_pc;
            end else if (issue) begin
                pc_q  <= pc_next(pc_q);
                tag_q <= pc_q;
            end
            if (bus.halt && !bus.redirect)
                halted_q <= 1'b1;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = ~fifo_empty;
    assign bus.id_instr  = head.instr;
    assign bus.id_pc     = head.pc;
    assign bus.id_pc1    = fifo_empty ? '0 : pc_next(head.pc);
    assign bus.halted    = halted_q;

    // The credit rule keeps the FIFO from ever seeing a push while full without a pop.
    always_comb begin
        assert (reset || !(enq && fifo_full && !deq));
    end

endmodule
